// File: rtl/mpu_load_store_ctrl.sv
// Moves whole matrices between an element stream and the matrix register file.
// Row-major traversal, one element per cycle, single-cycle done/error pulses.
//
//   state        | meaning
//   IDLE         | waiting for a command, mpu_op_ready_out high
//   LOAD_MATRIX  | writing load-stream elements into the register file
//   STORE_MATRIX | reading register-file elements onto the store stream
module mpu_load_store_ctrl #(
    parameter int FP               = 32,
    parameter int M                = 5,
    parameter int N                = 5,
    parameter int MATRIX_REGISTERS = 16,
    localparam int MW = $clog2(M),
    localparam int NW = $clog2(N),
    localparam int AW = $clog2(MATRIX_REGISTERS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    mpu_op_in,
    input  logic          mpu_op_valid_in,
    output logic          mpu_op_ready_out,
    input  logic [AW-1:0] mpu_reg_in,
    input  logic [MW-1:0] mpu_m_in,
    input  logic [NW-1:0] mpu_n_in,
    input  logic [FP-1:0] load_data_in,
    input  logic          load_valid_in,
    output logic          load_ready_out,
    output logic [FP-1:0] store_data_out,
    output logic          store_valid_out,
    input  logic          store_ready_in,
    output logic          rf_wr_en_out,
    output logic [FP-1:0] rf_wdata_out,
    output logic [AW-1:0] rf_addr_out,
    output logic [MW-1:0] rf_row_out,
    output logic [NW-1:0] rf_col_out,
    input  logic [FP-1:0] rf_rdata_in,
    output logic          done_out,
    output logic          error_out
);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mpu_operation_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_MATRIX,
        STORE_MATRIX
    } state_t;

    localparam logic [MW-1:0] M_MAX = MW'(M);
    localparam logic [NW-1:0] N_MAX = NW'(N);

    state_t        r_state;
    logic [AW-1:0] r_reg;
    logic [MW-1:0] r_m;
    logic [NW-1:0] r_n;
    logic [MW-1:0] r_row;
    logic [NW-1:0] r_col;
    logic [FP-1:0] r_store_data;
    logic          r_store_valid;
    logic          r_all_captured;
    logic          r_done;
    logic          r_error;

    logic          w_accept;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_dims_bad;
    logic          w_load_hs;
    logic          w_store_adv;
    logic          w_last;
    logic          w_col_wrap;
    logic [MW-1:0] w_next_row;
    logic [NW-1:0] w_next_col;

    assign w_accept    = mpu_op_valid_in && (r_state == IDLE);
    assign w_is_load   = (mpu_op_in == OP_LOAD);
    assign w_is_store  = (mpu_op_in == OP_STORE);
    assign w_dims_bad  = (mpu_m_in == '0) || (mpu_n_in == '0) ||
                         (mpu_m_in > M_MAX) || (mpu_n_in > N_MAX);
    assign w_load_hs   = (r_state == LOAD_MATRIX) && load_valid_in;
    // The output register may refill when empty or when its element leaves this cycle.
    assign w_store_adv = (r_state == STORE_MATRIX) && (!r_store_valid || store_ready_in);
    assign w_col_wrap  = (r_col == r_n - NW'(1));
    assign w_last      = (r_row == r_m - MW'(1)) && w_col_wrap;
    assign w_next_col  = w_col_wrap ? '0 : r_col + NW'(1);
    assign w_next_row  = w_col_wrap ? r_row + MW'(1) : r_row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_reg          <= '0;
            r_m            <= '0;
            r_n            <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_store_data   <= '0;
            r_store_valid  <= 1'b0;
            r_all_captured <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept && (w_is_load || w_is_store)) begin
                        if (w_dims_bad) begin
                            r_error <= 1'b1;
                        end else begin
                            r_reg          <= mpu_reg_in;
                            r_m            <= mpu_m_in;
                            r_n            <= mpu_n_in;
                            r_row          <= '0;
                            r_col          <= '0;
                            r_all_captured <= 1'b0;
                            r_state        <= w_is_load ? LOAD_MATRIX : STORE_MATRIX;
                        end
                    end
                end
                LOAD_MATRIX: begin
                    if (w_load_hs) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_row <= w_next_row;
                            r_col <= w_next_col;
                        end
                    end
                end
                STORE_MATRIX: begin
                    if (w_store_adv) begin
                        if (r_all_captured) begin
                            r_store_valid <= 1'b0;
                            r_done        <= 1'b1;
                            r_state       <= IDLE;
                        end else begin
                            r_store_data  <= rf_rdata_in;
                            r_store_valid <= 1'b1;
                            if (w_last) begin
                                r_all_captured <= 1'b1;
                            end else begin
                                r_row <= w_next_row;
                                r_col <= w_next_col;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mpu_op_ready_out = (r_state == IDLE);
    assign load_ready_out   = (r_state == LOAD_MATRIX);
    assign rf_wr_en_out     = w_load_hs;
    assign rf_wdata_out     = w_load_hs ? load_data_in : '0;
    assign rf_addr_out      = r_reg;
    assign rf_row_out       = r_row;
    assign rf_col_out       = r_col;
    assign store_data_out   = r_store_data;
    assign store_valid_out  = r_store_valid;
    assign done_out         = r_done;
    assign error_out        = r_error;

endmodule

// File: tb/tb_mpu_load_store_ctrl.sv
// Directed bench for mpu_load_store_ctrl with a behavioural register file.
// Command-response vectors are table driven; transfers use hand-written sequences.
module tb_mpu_load_store_ctrl;

    localparam logic [1:0] NOP   = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mpu_op_in;
    logic        mpu_op_valid_in;
    logic        mpu_op_ready_out;
    logic [3:0]  mpu_reg_in;
    logic [2:0]  mpu_m_in;
    logic [2:0]  mpu_n_in;
    logic [31:0] load_data_in;
    logic        load_valid_in;
    logic        load_ready_out;
    logic [31:0] store_data_out;
    logic        store_valid_out;
    logic        store_ready_in;
    logic        rf_wr_en_out;
    logic [31:0] rf_wdata_out;
    logic [3:0]  rf_addr_out;
    logic [2:0]  rf_row_out;
    logic [2:0]  rf_col_out;
    logic [31:0] rf_rdata_in;
    logic        done_out;
    logic        error_out;

    mpu_load_store_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mpu_op_in        (mpu_op_in),
        .mpu_op_valid_in  (mpu_op_valid_in),
        .mpu_op_ready_out (mpu_op_ready_out),
        .mpu_reg_in       (mpu_reg_in),
        .mpu_m_in         (mpu_m_in),
        .mpu_n_in         (mpu_n_in),
        .load_data_in     (load_data_in),
        .load_valid_in    (load_valid_in),
        .load_ready_out   (load_ready_out),
        .store_data_out   (store_data_out),
        .store_valid_out  (store_valid_out),
        .store_ready_in   (store_ready_in),
        .rf_wr_en_out     (rf_wr_en_out),
        .rf_wdata_out     (rf_wdata_out),
        .rf_addr_out      (rf_addr_out),
        .rf_row_out       (rf_row_out),
        .rf_col_out       (rf_col_out),
        .rf_rdata_in      (rf_rdata_in),
        .done_out         (done_out),
        .error_out        (error_out)
    );

    always #5 clk = ~clk;

    // Register file model, indexed {reg,row,col}; combinational read.
    logic [31:0] mem [0:1023];
    assign rf_rdata_in = mem[{rf_addr_out, rf_row_out, rf_col_out}];
    always @(posedge clk) begin
        if (rf_wr_en_out) mem[{rf_addr_out, rf_row_out, rf_col_out}] <= rf_wdata_out;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  loc;
        logic [31:0] data;
    } wr_t;

    wr_t         wlog[$];
    logic [31:0] slog[$];
    int          done_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (rf_wr_en_out) wlog.push_back('{{rf_addr_out, rf_row_out, rf_col_out}, rf_wdata_out});
        if (store_valid_out && store_ready_in) slog.push_back(store_data_out);
        if (done_out) done_cnt++;
        if (reset_n && prev_stall) begin
            total++;
            if (!(store_valid_out === 1'b1 && store_data_out === prev_data)) begin
                bad++;
                $display("FAIL store_stable: got valid=%b data=%h want valid=1 data=%h",
                         store_valid_out, store_data_out, prev_data);
            end
        end
        prev_stall = reset_n && store_valid_out && !store_ready_in;
        prev_data  = store_data_out;
    end

    logic [31:0] fp_tab [9];

    function automatic logic [31:0] exp_data(input logic [31:0] base, input int i);
        return (base == 32'd0) ? fp_tab[i] : base + 32'(i);
    endfunction

    task automatic send_cmd(input logic [1:0] op, input int rg, input int m, input int n);
        mpu_op_in       = op;
        mpu_reg_in      = 4'(rg);
        mpu_m_in        = 3'(m);
        mpu_n_in        = 3'(n);
        mpu_op_valid_in = 1'b1;
        @(negedge clk);
        chk("cmd_ready", {31'd0, mpu_op_ready_out}, 32'd1);
        @(posedge clk);
        #1;
        mpu_op_valid_in = 1'b0;
        mpu_op_in       = NOP;
    endtask

    task automatic do_load(input int rg, input int m, input int n, input logic [31:0] base,
                           input bit inject, input string tag);
        int d0;
        int cnt;
        cnt = m * n;
        wlog.delete();
        d0 = done_cnt;
        send_cmd(LOAD, rg, m, n);
        for (int i = 0; i < cnt; i++) begin
            load_valid_in = 1'b1;
            load_data_in  = exp_data(base, i);
            if (inject && i == 2) begin
                mpu_op_in       = STORE;
                mpu_reg_in      = 4'd1;
                mpu_m_in        = 3'd2;
                mpu_n_in        = 3'd2;
                mpu_op_valid_in = 1'b1;
            end
            @(negedge clk);
            chk({tag, "_busy_ready"}, {31'd0, mpu_op_ready_out}, 32'd0);
            chk({tag, "_load_ready"}, {31'd0, load_ready_out}, 32'd1);
            @(posedge clk);
            #1;
            mpu_op_valid_in = 1'b0;
            mpu_op_in       = NOP;
        end
        load_valid_in = 1'b0;
        load_data_in  = 32'd0;
        chk({tag, "_done"}, {31'd0, done_out}, 32'd1);
        chk({tag, "_idle_ready"}, {31'd0, mpu_op_ready_out}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done_out}, 32'd0);
        chk({tag, "_no_store"}, {31'd0, store_valid_out}, 32'd0);
        chk({tag, "_wr_count"}, 32'(wlog.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < wlog.size(); i++) begin
            chk({tag, "_wr_loc"}, {22'd0, wlog[i].loc}, {22'd0, 4'(rg), 3'(i / n), 3'(i % n)});
            chk({tag, "_wr_data"}, wlog[i].data, exp_data(base, i));
        end
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic do_store(input int rg, input int m, input int n, input logic [31:0] base,
                            input bit toggle, input string tag);
        int d0;
        int cnt;
        int k;
        bit seen;
        cnt  = m * n;
        seen = 1'b0;
        k    = 0;
        slog.delete();
        d0 = done_cnt;
        store_ready_in = 1'b1;
        send_cmd(STORE, rg, m, n);
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done_out) begin
                seen = 1'b1;
                k    = c;
            end else begin
                store_ready_in = toggle ? ~store_ready_in : 1'b1;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (!toggle) chk({tag, "_latency"}, 32'(k), 32'(cnt + 1));
        chk({tag, "_valid_dropped"}, {31'd0, store_valid_out}, 32'd0);
        chk({tag, "_count"}, 32'(slog.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < slog.size(); i++) begin
            chk({tag, "_data"}, slog[i], exp_data(base, i));
        end
        store_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_idle_ready"}, {31'd0, mpu_op_ready_out}, 32'd1);
    endtask

    typedef struct {
        logic [1:0] op;
        int         m;
        int         n;
        logic       exp_err;
    } vec_t;

    vec_t vt[8];

    initial begin
        int d0;
        fp_tab[0] = 32'h3F800000; fp_tab[1] = 32'h40000000; fp_tab[2] = 32'h40400000;
        fp_tab[3] = 32'h40800000; fp_tab[4] = 32'h40A00000; fp_tab[5] = 32'h40C00000;
        fp_tab[6] = 32'h40E00000; fp_tab[7] = 32'h41000000; fp_tab[8] = 32'h41100000;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        vt[0] = '{LOAD,  6, 3, 1'b1};
        vt[1] = '{LOAD,  3, 0, 1'b1};
        vt[2] = '{LOAD,  0, 0, 1'b1};
        vt[3] = '{LOAD,  7, 7, 1'b1};
        vt[4] = '{STORE, 0, 2, 1'b1};
        vt[5] = '{STORE, 2, 6, 1'b1};
        vt[6] = '{STORE, 5, 6, 1'b1};
        vt[7] = '{NOP,   3, 3, 1'b0};

        reset_n         = 1'b0;
        mpu_op_in       = NOP;
        mpu_op_valid_in = 1'b0;
        mpu_reg_in      = 4'd0;
        mpu_m_in        = 3'd0;
        mpu_n_in        = 3'd0;
        load_data_in    = 32'd0;
        load_valid_in   = 1'b0;
        store_ready_in  = 1'b1;
        #3;
        chk("rst_op_ready", {31'd0, mpu_op_ready_out}, 32'd1);
        chk("rst_outputs", {load_ready_out, store_valid_out, rf_wr_en_out, done_out, error_out},
            32'd0);
        chk("rst_addr", {22'd0, rf_addr_out, rf_row_out, rf_col_out}, 32'd0);
        chk("rst_data", store_data_out | rf_wdata_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            send_cmd(vt[v].op, 2, vt[v].m, vt[v].n);
            chk("cmd_error", {31'd0, error_out}, {31'd0, vt[v].exp_err});
            chk("cmd_stays_idle", {31'd0, mpu_op_ready_out}, 32'd1);
            chk("cmd_no_load_ready", {31'd0, load_ready_out}, 32'd0);
            @(negedge clk);
            chk("cmd_no_write", {31'd0, rf_wr_en_out}, 32'd0);
            @(posedge clk);
            #1;
            chk("cmd_error_pulse", {31'd0, error_out}, 32'd0);
        end

        // 3x3 load with a STORE presented mid-transfer, then read it back with a stalling peer.
        do_load(3, 3, 3, 32'd0, 1'b1, "ld_3x3");
        do_store(3, 3, 3, 32'd0, 1'b1, "st_3x3");

        // Abort a load after four elements.
        wlog.delete();
        d0 = done_cnt;
        send_cmd(LOAD, 5, 3, 3);
        for (int i = 0; i < 4; i++) begin
            load_valid_in = 1'b1;
            load_data_in  = 32'h200 + 32'(i);
            @(posedge clk);
            #1;
        end
        load_data_in = 32'h2FF;
        chk("abort_pre_writes", 32'(wlog.size()), 32'd4);
        reset_n = 1'b0;
        #1;
        chk("abort_op_ready", {31'd0, mpu_op_ready_out}, 32'd1);
        chk("abort_outputs", {load_ready_out, store_valid_out, rf_wr_en_out, done_out, error_out},
            32'd0);
        chk("abort_addr", {22'd0, rf_addr_out, rf_row_out, rf_col_out}, 32'd0);
        chk("abort_wdata", rf_wdata_out, 32'd0);
        wlog.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        load_valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_no_writes", 32'(wlog.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        do_load(6, 2, 2, 32'h300, 1'b0, "ld_2x2");

        // Minimum and maximum dimensions.
        do_load(9, 1, 1, 32'hDEADBEEF, 1'b0, "ld_1x1");
        do_load(10, 5, 5, 32'h1000, 1'b0, "ld_5x5");
        do_store(10, 5, 5, 32'h1000, 1'b0, "st_5x5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mpu_load_store_ctrl.md
MPU_LOAD_STORE_CTRL -- requirements
Module: mpu_load_store_ctrl

Interface
REQ-001 Parameter FP, 32, floating-point element width (global_defs::FP).
REQ-002 Parameter M, 5, maximum matrix rows; row ports are MBITS+1 = 3 bits wide.
REQ-003 Parameter N, 5, maximum matrix columns; column ports are NBITS+1 = 3 bits wide.
REQ-004 Parameter MATRIX_REGISTERS, 16, register-file depth; address ports are MATRIX_REG_BITS+1 = 4 bits wide.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port mpu_op_in, input, 2 bits: mpu_pkg::mpu_operation_t (NOP/LOAD/STORE).
REQ-009 Ports mpu_op_valid_in (input, 1 bit) and mpu_op_ready_out (output, 1 bit): command handshake.
REQ-010 Ports mpu_reg_in (input, 4 bits), mpu_m_in (input, 3 bits) and mpu_n_in (input, 3 bits): target register, rows and columns.
REQ-011 Ports load_data_in (input, FP bits), load_valid_in (input, 1 bit) and load_ready_out (output, 1 bit): element stream in.
REQ-012 Ports store_data_out (output, FP bits), store_valid_out (output, 1 bit) and store_ready_in (input, 1 bit): element stream out.
REQ-013 Register-file write ports: rf_wr_en_out (1 bit), rf_wdata_out (FP bits).
REQ-014 Register-file address ports, all outputs: rf_addr_out (4 bits), rf_row_out (3 bits), rf_col_out (3 bits).
REQ-015 Register-file read data: rf_rdata_in, input, FP bits, combinational read of the currently driven address/row/col.
REQ-016 Status outputs, 1 bit each: done_out (1-cycle pulse) and error_out (1-cycle pulse).

Function
REQ-017 The FSM SHALL have three states: IDLE, LOAD_MATRIX and STORE_MATRIX.
REQ-018 mpu_op_ready_out SHALL be high only in IDLE; a command is accepted when valid and ready are both high on a rising edge.
REQ-019 An accepted NOP SHALL have no effect.
REQ-020 An accepted LOAD or STORE with m=0, n=0, m>M or n>N SHALL pulse error_out for the next cycle and leave the FSM in IDLE.
REQ-021 An accepted valid LOAD SHALL latch reg, m and n, clear the row and column counters, and enter LOAD_MATRIX; STORE SHALL do the same and enter STORE_MATRIX.
REQ-022 Traversal SHALL be row-major: col increments; at col=n-1, col wraps to 0 and row increments.
REQ-023 LOAD_MATRIX: load_ready_out=1; each load handshake SHALL drive rf_wr_en_out=1 combinationally that same cycle, with rf_wdata_out=load_data_in at the current row/col, then advance the counters.
REQ-024 LOAD completion: the handshake at (m-1,n-1) SHALL return the FSM to IDLE next cycle with a done_out pulse in that cycle; exactly m*n writes occur.
REQ-025 STORE_MATRIX: when store_valid_out=0 or store_ready_in=1, the block SHALL register rf_rdata_in into store_data_out, set store_valid_out and advance the counters until all m*n elements are captured.
REQ-026 store_data_out and store_valid_out SHALL hold stable while store_valid_out=1 and store_ready_in=0.
REQ-027 STORE completion: after the last element's handshake with nothing pending, store_valid_out SHALL drop, done_out SHALL pulse and the FSM SHALL return to IDLE.
REQ-028 Throughput SHALL be one element per cycle when the peer holds valid/ready high.
REQ-029 rf_wr_en_out SHALL be 0 outside LOAD_MATRIX; load_ready_out SHALL be 0 outside LOAD_MATRIX.
REQ-030 Commands presented while busy SHALL be neither accepted nor queued.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, zero all counters and latched fields, and drive all outputs to 0 except mpu_op_ready_out, which SHALL be 1.
REQ-032 Reset asserted mid-LOAD or mid-STORE SHALL abort the transfer without a done_out pulse; no further rf writes occur.

Verification
REQ-033 LOAD reg=3, m=3, n=3, nine elements 1.0..9.0 back-to-back -> nine rf writes (3,0,0)..(3,2,2), done_out in cycle 10 after acceptance.
REQ-034 STORE reg=3, m=3, n=3 with store_ready_in toggling 1,0,1,0 -> 9 outputs in row-major order, data stable during stalls, single done_out pulse.
REQ-035 LOAD with m=6 or n=0 -> error_out pulse, no rf_wr_en_out, mpu_op_ready_out stays 1.
REQ-036 STORE command issued during LOAD -> ignored; LOAD completes normally.
REQ-037 reset_n low after the 4th LOAD element -> outputs zero, ready=1; a new 2x2 LOAD then writes from (0,0).
REQ-038 1x1 LOAD, then 5x5 STORE at max dims -> correct wrap at col=4 and row=4, exactly 1 and 25 transfers respectively.
